// File: rtl/ram_arbiter.sv
// Round-robin, bounded-burst arbiter that shares one single-port RAM between
// requesters A and B. Grants are combinational; read data returns one clock later.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

   logic                  r_last;
   logic [3:0]            r_cnt;
   logic                  r_a_rvalid;
   logic                  r_b_rvalid;
   logic [DATA_WIDTH-1:0] r_a_rdata;
   logic [DATA_WIDTH-1:0] r_b_rdata;
   logic                  w_gnt_a;
   logic                  w_gnt_b;
   logic                  w_win;

   // Under contention the previous owner keeps the RAM until its burst budget is spent.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (rst_n) begin
         if (a_req && b_req) begin
            if (r_cnt < LP_MAX) begin
               w_gnt_a = ~r_last;
               w_gnt_b = r_last;
            end else begin
               w_gnt_a = r_last;
               w_gnt_b = ~r_last;
            end
         end else begin
            w_gnt_a = a_req;
            w_gnt_b = b_req;
         end
      end
   end

   assign w_win = w_gnt_b;

   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (w_gnt_a) begin
         ram_addr  = a_addr;
         ram_wdata = a_wdata;
         ram_we    = a_we;
      end else if (w_gnt_b) begin
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
         ram_we    = b_we;
      end
   end

   // Reset to "B owned a full burst" so A wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
         r_cnt  <= LP_MAX;
      end else if (w_gnt_a || w_gnt_b) begin
         if (w_win == r_last) begin
            if (r_cnt < LP_MAX) r_cnt <= r_cnt + 4'd1;
         end else begin
            r_last <= w_win;
            r_cnt  <= 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= w_gnt_a && !a_we;
         r_b_rvalid <= w_gnt_b && !b_we;
         if (w_gnt_a && !a_we) r_a_rdata <= ram_rdata;
         if (w_gnt_b && !b_we) r_b_rdata <= ram_rdata;
      end
   end

   assign a_gnt    = w_gnt_a;
   assign b_gnt    = w_gnt_b;
   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign a_rdata  = r_a_rdata;
   assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (MAX_BURST 4 and 1), each with its own RAM,
// checked every cycle against a burst-run model plus directed literal expectations.
module tb_ram_arbiter;
   localparam int AW = 4;
   localparam int DW = 8;

   typedef struct {
      string nm;
      string act;
      string exp;
   } lit_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ram_load;
   logic          a_req [2], a_we [2], b_req [2], b_we [2];
   logic [AW-1:0] a_addr [2], b_addr [2], ram_addr [2];
   logic [DW-1:0] a_wdata [2], b_wdata [2], ram_wdata [2], ram_rdata [2];
   logic          a_gnt [2], a_rvalid [2], b_gnt [2], b_rvalid [2], ram_we [2];
   logic [DW-1:0] a_rdata [2], b_rdata [2];
   logic [DW-1:0] mem [2][16];

   int            m_last [2], m_run [2], m_eg [2];
   logic          m_arv [2], m_brv [2];
   logic [DW-1:0] m_ard [2], m_brd [2];
   logic [DW-1:0] sm [2][16];
   string         glog [2];
   lit_t          lits [$];
   int            lit_done = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
      .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
      .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
      .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
      .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]),
      .ram_rdata(ram_rdata[0]));

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
      .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
      .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
      .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
      .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]),
      .ram_rdata(ram_rdata[1]));

   function automatic logic [DW-1:0] init_val(input int k);
      return DW'(k * 17 + 1);
   endfunction

   function automatic int mbv(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   // RAM behind each arbiter: combinational read, write on the edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ram_load) begin
            for (int k = 0; k < 16; k++) mem[i][k] <= init_val(k);
         end else if (ram_we[i]) begin
            mem[i][ram_addr[i]] <= ram_wdata[i];
         end
      end
   end
   assign ram_rdata[0] = mem[0][ram_addr[0]];
   assign ram_rdata[1] = mem[1][ram_addr[1]];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: owner of last grant plus length of its current run of grants.
   always @(posedge clk or negedge clk) begin
      if (clk) begin
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               m_arv[i] = (m_eg[i] == 0) && !a_we[i];
               m_brv[i] = (m_eg[i] == 1) && !b_we[i];
               if (m_arv[i]) m_ard[i] = sm[i][a_addr[i]];
               if (m_brv[i]) m_brd[i] = sm[i][b_addr[i]];
               if (m_eg[i] == 0 && a_we[i]) sm[i][a_addr[i]] = a_wdata[i];
               if (m_eg[i] == 1 && b_we[i]) sm[i][b_addr[i]] = b_wdata[i];
               if (m_eg[i] >= 0) begin
                  if (m_eg[i] == m_last[i]) m_run[i]++;
                  else begin
                     m_last[i] = m_eg[i];
                     m_run[i]  = 1;
                  end
               end
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ram_load)
               for (int k = 0; k < 16; k++) sm[i][k] = init_val(k);
            m_eg[i] = -1;
            if (!rst_n) begin
               m_last[i] = 1;
               m_run[i]  = mbv(i);
               m_arv[i]  = 1'b0;
               m_brv[i]  = 1'b0;
               m_ard[i]  = '0;
               m_brd[i]  = '0;
            end else if (a_req[i] && b_req[i]) begin
               m_eg[i] = (m_run[i] >= mbv(i)) ? 1 - m_last[i] : m_last[i];
            end else if (a_req[i]) begin
               m_eg[i] = 0;
            end else if (b_req[i]) begin
               m_eg[i] = 1;
            end
            chk($sformatf("u%0d.a_gnt", i), int'(a_gnt[i]), int'(m_eg[i] == 0));
            chk($sformatf("u%0d.b_gnt", i), int'(b_gnt[i]), int'(m_eg[i] == 1));
            chk($sformatf("u%0d.ram_we", i), int'(ram_we[i]),
                (m_eg[i] == 0) ? int'(a_we[i]) : (m_eg[i] == 1) ? int'(b_we[i]) : 0);
            chk($sformatf("u%0d.ram_addr", i), int'(ram_addr[i]),
                (m_eg[i] == 0) ? int'(a_addr[i]) : (m_eg[i] == 1) ? int'(b_addr[i]) : 0);
            chk($sformatf("u%0d.ram_wdata", i), int'(ram_wdata[i]),
                (m_eg[i] == 0) ? int'(a_wdata[i]) : (m_eg[i] == 1) ? int'(b_wdata[i]) : 0);
            chk($sformatf("u%0d.a_rvalid", i), int'(a_rvalid[i]), int'(m_arv[i]));
            chk($sformatf("u%0d.b_rvalid", i), int'(b_rvalid[i]), int'(m_brv[i]));
            chk($sformatf("u%0d.a_rdata", i), int'(a_rdata[i]), int'(m_ard[i]));
            chk($sformatf("u%0d.b_rdata", i), int'(b_rdata[i]), int'(m_brd[i]));
            if (a_gnt[i]) glog[i] = {glog[i], "A"};
            if (b_gnt[i]) glog[i] = {glog[i], "B"};
         end
         while (lit_done < lits.size()) begin
            n_tests++;
            if (lits[lit_done].act != lits[lit_done].exp) begin
               n_fail++;
               $display("FAIL %s: got %s, expected %s", lits[lit_done].nm,
                        lits[lit_done].act, lits[lit_done].exp);
            end
            lit_done++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic seta(input int i, input logic r, input logic w, input int ad, input int wd);
      a_req[i] = r; a_we[i] = w; a_addr[i] = AW'(ad); a_wdata[i] = DW'(wd);
   endtask

   task automatic setb(input int i, input logic r, input logic w, input int ad, input int wd);
      b_req[i] = r; b_we[i] = w; b_addr[i] = AW'(ad); b_wdata[i] = DW'(wd);
   endtask

   task automatic lits_s(input string nm, input string act, input string exp);
      lit_t t;
      t.nm = nm; t.act = act; t.exp = exp;
      lits.push_back(t);
   endtask

   task automatic litn(input string nm, input int act, input int exp);
      lits_s(nm, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   function automatic string since(input int i, input int st);
      if (glog[i].len() <= st) return "";
      return glog[i].substr(st, glog[i].len() - 1);
   endfunction

   initial begin
      int  st;
      int  ka, kb, plen;
      byte c;
      rst_n = 1'b0;
      ram_load = 1'b1;
      for (int i = 0; i < 2; i++) begin
         seta(i, 0, 0, 0, 0);
         setb(i, 0, 0, 0, 0);
         glog[i] = "";
         m_eg[i] = -1;
      end
      cyc(2);
      ram_load = 1'b0;
      seta(0, 1, 1, 3, 'h55);
      cyc(1);
      litn("rst_a_gnt", int'(a_gnt[0]), 0);
      litn("rst_ram_we", int'(ram_we[0]), 0);
      litn("rst_a_rdata", int'(a_rdata[0]), 0);

      // Contention with MAX_BURST 4: bursts of four, A first.
      seta(0, 1, 0, 3, 0);
      setb(0, 1, 0, 5, 0);
      st = glog[0].len();
      rst_n = 1'b1;
      cyc(9);
      lits_s("t1_order", since(0, st), "AAAABBBBA");
      litn("t1_a_rvalid", int'(a_rvalid[0]), 1);
      litn("t1_a_rdata", int'(a_rdata[0]), 'h34);
      litn("t1_b_rdata", int'(b_rdata[0]), 86);

      // Write then read of the same address.
      setb(0, 0, 0, 0, 0);
      seta(0, 1, 1, 7, 'hA5);
      cyc(1);
      seta(0, 1, 0, 7, 0);
      cyc(1);
      litn("t2_a_rvalid", int'(a_rvalid[0]), 1);
      litn("t2_a_rdata", int'(a_rdata[0]), 'hA5);
      litn("t2_b_rvalid", int'(b_rvalid[0]), 0);
      seta(0, 0, 0, 0, 0);
      cyc(1);

      // Long A run saturates the count; a newcomer B is served at once.
      seta(0, 1, 0, 1, 0);
      cyc(10);
      st = glog[0].len();
      setb(0, 1, 0, 2, 0);
      cyc(1);
      setb(0, 0, 0, 0, 0);
      cyc(1);
      lits_s("t3_order", since(0, st), "BA");
      litn("t3_b_rdata", int'(b_rdata[0]), 'h23);
      seta(0, 0, 0, 0, 0);

      // Idle gap must not disturb ownership: B keeps its unfinished burst.
      setb(0, 1, 0, 8, 0);
      cyc(2);
      setb(0, 0, 0, 0, 0);
      cyc(1);
      litn("t5_idle_we", int'(ram_we[0]), 0);
      litn("t5_idle_addr", int'(ram_addr[0]), 0);
      cyc(2);
      litn("t5_idle_rvalid", int'(b_rvalid[0]), 0);
      st = glog[0].len();
      seta(0, 1, 0, 4, 0);
      setb(0, 1, 0, 6, 0);
      cyc(1);
      lits_s("t5_tie", since(0, st), "B");
      seta(0, 0, 0, 0, 0);
      setb(0, 0, 0, 0, 0);
      cyc(1);

      // Reset in the middle of a B write burst.
      setb(0, 1, 1, 9, 'h11);
      cyc(1);
      setb(0, 1, 1, 10, 'h77);
      rst_n = 1'b0;
      #1;
      litn("t6_b_gnt", int'(b_gnt[0]), 0);
      litn("t6_ram_we", int'(ram_we[0]), 0);
      litn("t6_b_rvalid", int'(b_rvalid[0]), 0);
      cyc(2);
      litn("t6_mem10", int'(mem[0][10]), 171);
      litn("t6_mem9", int'(mem[0][9]), 'h11);
      seta(0, 1, 0, 2, 0);
      setb(0, 1, 0, 4, 0);
      st = glog[0].len();
      rst_n = 1'b1;
      cyc(1);
      lits_s("t6_tie", since(0, st), "A");
      seta(0, 0, 0, 0, 0);
      setb(0, 0, 0, 0, 0);
      cyc(1);

      // MAX_BURST 1: both sides write four words each, strictly alternating.
      ka = 0;
      kb = 0;
      seta(1, 1, 1, 0, 'hA0);
      setb(1, 1, 1, 8, 'hB0);
      st = glog[1].len();
      for (int t = 0; t < 12 && !(ka == 4 && kb == 4); t++) begin
         plen = glog[1].len();
         cyc(1);
         if (glog[1].len() > plen) begin
            c = glog[1].getc(glog[1].len() - 1);
            if (c == "A") begin
               ka++;
               if (ka == 4) seta(1, 0, 0, 0, 0);
               else seta(1, 1, 1, ka, 'hA0 + ka);
            end else begin
               kb++;
               if (kb == 4) setb(1, 0, 0, 0, 0);
               else setb(1, 1, 1, 8 + kb, 'hB0 + kb);
            end
         end
      end
      seta(1, 0, 0, 0, 0);
      setb(1, 0, 0, 0, 0);
      cyc(1);
      lits_s("t4_order", since(1, st), "ABABABAB");
      for (int k = 0; k < 4; k++) begin
         litn($sformatf("t4_memA%0d", k), int'(mem[1][k]), 'hA0 + k);
         litn($sformatf("t4_memB%0d", k), int'(mem[1][8 + k]), 'hB0 + k);
      end
      cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
